// File: rtl/prt_dprx_vid_crc_check.sv
// prt_dprx_vid_crc_check: per-frame CRC32 of 192-bit pixel words checked
// against the CRC carried in the AE_SDP. Optional macro: PRT_DPRX_CRC_ERR_CNT_EN.
module prt_dprx_vid_crc_check #(
    parameter logic [7:0]  SDP_TYPE    = 8'h20,
    parameter int unsigned SDP_TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cke,
    input  logic         vsync,
    input  logic [191:0] pix_data,
    input  logic         pix_valid,
    input  logic         sdp_valid,
    input  logic [319:0] sdp_payload,
    output logic         res_valid,
    output logic         res_ok,
    output logic         res_timeout,
    output logic [31:0]  crc_frame,
    output logic [31:0]  crc_rx,
    output logic         sdp_orphan,
    output logic [15:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCUM    = 2'd1,
        WAIT_SDP = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(SDP_TIMEOUT - 1);

    // Reflected CRC-32, bit 0 of the word consumed first
    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [191:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 192; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic        vsync_d;
    logic [31:0] crc_acc;
    logic [15:0] to_cnt;
    logic        rise;
    logic        sdp_hit;
    logic        to_hit;
    logic [31:0] sdp_crc;
    logic        res_valid_nxt;
    logic        res_ok_nxt;
    logic        res_to_nxt;
    logic        frame_latch;
    logic        orphan_set;
    logic        unused_ok;

    assign rise      = vsync & ~vsync_d;
    assign sdp_crc   = sdp_payload[63:32];
    assign sdp_hit   = sdp_valid & (sdp_payload[15:8] == SDP_TYPE);
    assign to_hit    = (to_cnt == TO_LAST);
    assign unused_ok = ^{sdp_payload[319:64], sdp_payload[31:16],
                         sdp_payload[7:0]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (rise) state_nxt = ACCUM;
            ACCUM:    if (rise) state_nxt = WAIT_SDP;
            WAIT_SDP: begin
                if (rise)                  state_nxt = WAIT_SDP;
                else if (sdp_hit || to_hit) state_nxt = ACCUM;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Result / latch decode; the SDP wins over a timeout or vsync rise
    always_comb begin
        res_valid_nxt = 1'b0;
        res_ok_nxt    = 1'b0;
        res_to_nxt    = 1'b0;
        frame_latch   = 1'b0;
        orphan_set    = 1'b0;
        unique case (state)
            IDLE:     orphan_set = sdp_hit;
            ACCUM: begin
                orphan_set  = sdp_hit;
                frame_latch = rise;
            end
            WAIT_SDP: begin
                frame_latch   = rise;
                res_valid_nxt = sdp_hit | to_hit | rise;
                res_ok_nxt    = sdp_hit & (sdp_crc == crc_frame);
                res_to_nxt    = ~sdp_hit & (to_hit | rise);
            end
            default: ;
        endcase
    end

    // Vsync edge detect, CRC accumulator and SDP wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
            crc_acc <= 32'hFFFF_FFFF;
            to_cnt  <= '0;
        end else begin
            vsync_d <= vsync;
            if (vsync)                 crc_acc <= 32'hFFFF_FFFF;
            else if (pix_valid && cke) crc_acc <= crc_step(crc_acc, pix_data);
            if (rise)                  to_cnt <= '0;
            else if (state == WAIT_SDP) to_cnt <= to_cnt + 16'd1;
        end
    end

    // Registered results and captured CRCs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_ok      <= 1'b0;
            res_timeout <= 1'b0;
            crc_frame   <= '0;
            crc_rx      <= '0;
            sdp_orphan  <= 1'b0;
        end else begin
            res_valid   <= res_valid_nxt;
            res_ok      <= res_ok_nxt;
            res_timeout <= res_to_nxt;
            if (frame_latch)                      crc_frame <= ~crc_acc;
            if (sdp_hit && state == WAIT_SDP)     crc_rx    <= sdp_crc;
            if (orphan_set)                       sdp_orphan <= 1'b1;
        end
    end

`ifdef PRT_DPRX_CRC_ERR_CNT_EN
    logic [15:0] err_q;

    // Saturating count of failed or timed-out frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= '0;
        else if (res_valid && !res_ok && err_q != 16'hFFFF)
            err_q <= err_q + 16'd1;
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule
